// File: rtl/ascii_to_bcd_parser_if.sv
// Character-in / BCD-result-out handshake bundle for ascii_to_bcd_parser.
// Ports: asciiValid/asciiIn/asciiReady (character stream), bcdOutput/digitCount/parseError/bcdValid/bcdReady (result).
// Modports: master = parser side (drives asciiReady and the result), slave = source/sink side.
interface ascii_to_bcd_parser_if #(
  parameter int BCD_NUMBER_LENGTH = 3
);
  localparam int COUNT_WIDTH = $clog2(BCD_NUMBER_LENGTH + 1);

  logic                           asciiValid;
  logic [7:0]                     asciiIn;
  logic                           asciiReady;
  logic [4*BCD_NUMBER_LENGTH-1:0] bcdOutput;
  logic [COUNT_WIDTH-1:0]         digitCount;
  logic                           parseError;
  logic                           bcdValid;
  logic                           bcdReady;

  modport master (
    input  asciiValid, asciiIn, bcdReady,
    output asciiReady, bcdOutput, digitCount, parseError, bcdValid
  );

  modport slave (
    output asciiValid, asciiIn, bcdReady,
    input  asciiReady, bcdOutput, digitCount, parseError, bcdValid
  );
endinterface

// File: rtl/ascii_to_bcd_parser.sv
// Serial ASCII-to-BCD parser: accumulates decimal digits into a right-justified packed-BCD word.
// Latency: terminator accepted at edge k -> bcdValid after edge k; next character accepted no earlier than one edge after the result is consumed.
// Backpressure: asciiReady is low while a result is held; the result stays stable until bcdReady.
// Ports: clk, reset (synchronous, active-high), bus (ascii_to_bcd_parser_if.master).
// Optional: define ASCII_BACKSPACE_EN to make 8'h08 delete the last digit instead of corrupting the number.
module ascii_to_bcd_parser #(
  parameter int         BCD_NUMBER_LENGTH = 3,
  parameter logic [7:0] TERMINATOR        = 8'h0D
) (
  input  logic                  clk,
  input  logic                  reset,
  ascii_to_bcd_parser_if.master bus
);

  localparam int ACC_W       = 4 * BCD_NUMBER_LENGTH;
  localparam int COUNT_WIDTH = $clog2(BCD_NUMBER_LENGTH + 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_FULL = COUNT_WIDTH'(BCD_NUMBER_LENGTH);
  localparam logic [7:0] CHR_SPACE = 8'h20;
  localparam logic [7:0] CHR_BS    = 8'h08;

`ifdef ASCII_BACKSPACE_EN
  localparam bit BS_EN = 1'b1;
`else
  localparam bit BS_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    ACCUM   = 2'd1,
    DISCARD = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0]       bcd_out_q, bcd_out_d;
  logic [COUNT_WIDTH-1:0] digit_cnt_q, digit_cnt_d;
  logic                   perr_q, perr_d;
  logic                   bcd_vld_q, bcd_vld_d;
  logic                   ascii_rdy_q, ascii_rdy_d;

  logic       xfer;
  logic       is_digit;
  logic       is_term;
  logic       is_space;
  logic       is_bs;
  logic [3:0] dig;

  assign xfer     = bus.asciiValid && ascii_rdy_q;
  assign is_digit = (bus.asciiIn >= 8'h30) && (bus.asciiIn <= 8'h39);
  assign is_term  = (bus.asciiIn == TERMINATOR);
  assign is_space = (bus.asciiIn == CHR_SPACE);
  // Constant-folds to 0 when backspace support is compiled out, so 8'h08
  // then falls through to the invalid-character branches.
  assign is_bs    = BS_EN && (bus.asciiIn == CHR_BS);
  assign dig      = bus.asciiIn[3:0];

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    bcd_out_d   = bcd_out_q;
    digit_cnt_d = digit_cnt_q;
    perr_d      = perr_q;
    bcd_vld_d   = bcd_vld_q;

    unique case (state_q)
      EMPTY: begin
        if (xfer) begin
          if (is_digit) begin
            acc_d   = ACC_W'(dig);
            cnt_d   = COUNT_WIDTH'(1);
            state_d = ACCUM;
          end else if (is_space || is_term || is_bs) begin
            // Leading blanks, empty lines and stray backspaces are no-ops.
            state_d = EMPTY;
          end else begin
            state_d = DISCARD;
          end
        end
      end

      ACCUM: begin
        if (xfer) begin
          if (is_digit) begin
            if (cnt_q == CNT_FULL) begin
              acc_d   = '0;
              cnt_d   = '0;
              state_d = DISCARD;
            end else begin
              // Top digit is known to be zero here, so the left shift drops nothing.
              acc_d = (acc_q << 4) | ACC_W'(dig);
              cnt_d = cnt_q + COUNT_WIDTH'(1);
            end
          end else if (is_term) begin
            bcd_out_d   = acc_q;
            digit_cnt_d = cnt_q;
            perr_d      = 1'b0;
            bcd_vld_d   = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            state_d     = HOLD;
          end else if (is_bs) begin
            acc_d = acc_q >> 4;
            cnt_d = cnt_q - COUNT_WIDTH'(1);
            if (cnt_q == COUNT_WIDTH'(1)) begin
              state_d = EMPTY;
            end
          end else begin
            acc_d   = '0;
            cnt_d   = '0;
            state_d = DISCARD;
          end
        end
      end

      DISCARD: begin
        // Everything up to the terminator is swallowed; the terminator
        // still produces a result so the sink learns the entry was bad.
        if (xfer && is_term) begin
          bcd_out_d   = '0;
          digit_cnt_d = '0;
          perr_d      = 1'b1;
          bcd_vld_d   = 1'b1;
          state_d     = HOLD;
        end
      end

      HOLD: begin
        if (bus.bcdReady) begin
          bcd_out_d   = '0;
          digit_cnt_d = '0;
          perr_d      = 1'b0;
          bcd_vld_d   = 1'b0;
          acc_d       = '0;
          cnt_d       = '0;
          state_d     = EMPTY;
        end
      end

      default: begin
        state_d = EMPTY;
      end
    endcase

    // Registered ready: low for the whole time a result is held, and
    // back high on the same edge that hands the result off.
    ascii_rdy_d = (state_d != HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      acc_q       <= '0;
      cnt_q       <= '0;
      bcd_out_q   <= '0;
      digit_cnt_q <= '0;
      perr_q      <= 1'b0;
      bcd_vld_q   <= 1'b0;
      ascii_rdy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      bcd_out_q   <= bcd_out_d;
      digit_cnt_q <= digit_cnt_d;
      perr_q      <= perr_d;
      bcd_vld_q   <= bcd_vld_d;
      ascii_rdy_q <= ascii_rdy_d;
    end
  end

  assign bus.asciiReady = ascii_rdy_q;
  assign bus.bcdOutput  = bcd_out_q;
  assign bus.digitCount = digit_cnt_q;
  assign bus.parseError = perr_q;
  assign bus.bcdValid   = bcd_vld_q;

endmodule

// File: doc/ascii_to_bcd_parser.md
Name: ascii_to_bcd_parser

Overview:
- Serial ASCII-to-BCD parser. It is the receive-side counterpart of the existing BCD-to-ASCII converter.
- Accepts one ASCII character per handshake from a keyboard/UART-style source and accumulates decimal digits into a right-justified packed-BCD word.
- On a terminator character it presents the completed number, with digit count and error flag, to downstream game/display logic over a valid/ready handshake.

Parameters:
- BCD_NUMBER_LENGTH, 3, maximum number of BCD digits held; output width is 4*BCD_NUMBER_LENGTH.
- TERMINATOR, 8'h0D, ASCII code that ends a number.
- COUNT_WIDTH, $clog2(BCD_NUMBER_LENGTH+1), localparam width of digitCount.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- asciiValid  input  1  source has a character on asciiIn
- asciiIn  input  8  ASCII character
- asciiReady  output  1  parser can accept a character this cycle
- bcdOutput  output  4*BCD_NUMBER_LENGTH  packed BCD result, least significant digit in [3:0]
- digitCount  output  COUNT_WIDTH  number of digits parsed
- parseError  output  1  result invalid (bad character or overflow)
- bcdValid  output  1  result available
- bcdReady  input  1  sink accepts the result

Behaviour:
- Interface decision: single clock clk; reset is synchronous and active-high.
- All outputs are registered.
- Reset values: asciiReady=0, bcdValid=0, parseError=0, bcdOutput=0, digitCount=0, state=EMPTY. asciiReady rises on the first edge with reset low.
- Character transfer occurs on an edge where asciiValid && asciiReady.
- Digit means 8'h30..8'h39; its value is asciiIn-8'h30.
- States: EMPTY (no digits), ACCUM (1..N digits), DISCARD (number corrupted), HOLD (result presented).
- EMPTY:
  - digit -> load digit into [3:0], count=1, go to ACCUM.
  - space 8'h20 -> ignored.
  - TERMINATOR -> ignored; no empty results are produced.
  - any other character -> DISCARD.
- ACCUM:
  - digit with count<N -> reg={reg[4N-5:0],digit}, count+1.
  - digit with count==N -> DISCARD (overflow).
  - TERMINATOR -> HOLD.
  - any other character, including space -> DISCARD.
- DISCARD:
  - TERMINATOR -> HOLD with error.
  - all other characters are accepted and dropped.
- Entering HOLD, on the same edge that accepts the terminator:
  - bcdValid=1 and asciiReady=0.
  - Normal: bcdOutput=reg, digitCount=count, parseError=0.
  - Error: bcdOutput=0, digitCount=0, parseError=1.
- HOLD:
  - Outputs remain stable while bcdReady=0.
  - On an edge with bcdReady=1: bcdValid=0, parseError=0, reg/count/bcdOutput/digitCount cleared, asciiReady=1, go to EMPTY.
  - asciiValid during HOLD is not accepted, including the cycle bcdReady is high.
- Latency: terminator accepted at edge k -> bcdValid visible after edge k (one cycle). Result consumed at edge m -> next character accepted no earlier than edge m+1.
- Unused upper digits of bcdOutput read as 0 (right-justified, leading zeros).
- reset mid-number or during HOLD: partial/held result discarded, all outputs return to reset values.
- bcdReady outside HOLD: ignored.

Optional Feature:
- Macro ASCII_BACKSPACE_EN.
- Defined: 8'h08 is handled per state:
  - ACCUM: reg=reg>>4, count-1; count reaching 0 -> EMPTY.
  - EMPTY: ignored.
  - DISCARD: dropped, stays DISCARD.
- Undefined: 8'h08 is an ordinary invalid character (EMPTY/ACCUM -> DISCARD).

Test Plan:
- Reset, then '1','2','3',8'h0D one per cycle -> bcdValid=1, bcdOutput=12'h123, digitCount=3, parseError=0, asciiReady=0 until bcdReady.
- Space, '7', 8'h0D -> bcdOutput=12'h007, digitCount=1; lone 8'h0D in EMPTY -> no bcdValid.
- '1','2','3','4',8'h0D (overflow) and '4','A','5',8'h0D (bad character) -> parseError=1, bcdOutput=0, digitCount=0, bcdValid=1.
- Hold bcdReady=0 for 5 cycles with asciiValid=1, asciiIn='9' -> no transfer, outputs stable; pulse bcdReady one cycle -> bcdValid falls and asciiReady rises on that edge, then '9' is accepted the next edge.
- '5','6', reset for one cycle, '8',8'h0D -> bcdOutput=12'h008, digitCount=1.
- '1','2',8'h08,'9',8'h0D -> 12'h019, count 2 with ASCII_BACKSPACE_EN; parseError=1 without it.
